// File: rtl/fre_sweep.sv
// Linear frequency sweep sequencer for the DDS `fre` word (Hz): single, sawtooth or triangle.
// Optional pass-marker output enabled with FRE_SWEEP_MARKER_EN.
module fre_sweep #(
   parameter int FRE_W   = 24,
   parameter int DWELL_W = 24
) (
   input  logic               clk_100M,
   input  logic               rst,
   input  logic               start,
   input  logic               stop,
   input  logic [FRE_W-1:0]   f_start,
   input  logic [FRE_W-1:0]   f_stop,
   input  logic [FRE_W-1:0]   f_step,
   input  logic [DWELL_W-1:0] dwell,
   input  logic [1:0]         mode,
   output logic [FRE_W-1:0]   fre,
   output logic               busy,
   output logic               done,
   output logic               step_tick
`ifdef FRE_SWEEP_MARKER_EN
   ,
   input  logic [FRE_W-1:0]   f_marker,
   output logic               marker
`endif
);

   typedef enum logic [1:0] {IDLE, UP, DOWN, FINISH} state_t;
   localparam logic [1:0] M_REPEAT = 2'd1;
   localparam logic [1:0] M_TRI    = 2'd2;

   state_t             state;
   logic [FRE_W-1:0]   start_l, stop_l, step_l;
   logic [DWELL_W-1:0] dwell_l, cnt;
   logic [1:0]         mode_l;

   logic [FRE_W:0]     sum, diff;
   logic [DWELL_W:0]   cnt_nx;
   logic               term, up_top, dn_bot;

   always_comb begin
      sum    = {1'b0, fre} + {1'b0, step_l};
      diff   = {1'b0, fre} - {1'b0, step_l};
      cnt_nx = {1'b0, cnt} + {{DWELL_W{1'b0}}, 1'b1};
      // dwell of 0 behaves as 1: terminal count every cycle
      term   = cnt_nx >= {1'b0, dwell_l};
      up_top = sum[FRE_W] || (sum[FRE_W-1:0] >= stop_l);
      dn_bot = diff[FRE_W] || (diff[FRE_W-1:0] <= start_l);
   end

`ifdef FRE_SWEEP_MARKER_EN
   logic [FRE_W-1:0] mk_l;
   logic             armed;
`endif

   always_ff @(posedge clk_100M) begin
      if (rst) begin
         state <= IDLE; fre <= '0; busy <= 1'b0; done <= 1'b0; step_tick <= 1'b0;
         cnt <= '0; start_l <= '0; stop_l <= '0; step_l <= '0; dwell_l <= '0; mode_l <= '0;
`ifdef FRE_SWEEP_MARKER_EN
         mk_l <= '0; armed <= 1'b0; marker <= 1'b0;
`endif
      end else begin
         step_tick <= 1'b0;
         done      <= 1'b0;
`ifdef FRE_SWEEP_MARKER_EN
         marker    <= 1'b0;
`endif
         if (state == IDLE) begin
            cnt <= '0;
            if (start && !stop) begin
               start_l <= f_start; stop_l <= f_stop; step_l <= f_step;
               dwell_l <= dwell;   mode_l <= mode;
               fre <= f_start; step_tick <= 1'b1; busy <= 1'b1;
               // zero step or empty range: one dwell at f_start, then done
               state <= (f_step == '0 || f_start >= f_stop) ? FINISH : UP;
`ifdef FRE_SWEEP_MARKER_EN
               mk_l <= f_marker;
               marker <= (f_start >= f_marker);
               armed  <= !(f_start >= f_marker);
`endif
            end
         end else if (stop) begin
            state <= IDLE; busy <= 1'b0; done <= 1'b1; cnt <= '0;
         end else if (!term) begin
            cnt <= cnt_nx[DWELL_W-1:0];
         end else begin
            cnt <= '0;
            case (state)
               UP: begin
                  step_tick <= 1'b1;
                  if (mode_l == M_REPEAT && fre == stop_l) begin
                     fre <= start_l;
`ifdef FRE_SWEEP_MARKER_EN
                     marker <= (start_l >= mk_l);
                     armed  <= !(start_l >= mk_l);
`endif
                  end else if (up_top) begin
                     fre <= stop_l;
`ifdef FRE_SWEEP_MARKER_EN
                     marker <= armed && (stop_l >= mk_l);
                     if (stop_l >= mk_l) armed <= 1'b0;
                     if (mode_l == M_TRI) armed <= 1'b1;
`endif
                     if (mode_l == M_TRI)         state <= DOWN;
                     else if (mode_l != M_REPEAT) state <= FINISH;
                  end else begin
                     fre <= sum[FRE_W-1:0];
`ifdef FRE_SWEEP_MARKER_EN
                     marker <= armed && (sum[FRE_W-1:0] >= mk_l);
                     if (sum[FRE_W-1:0] >= mk_l) armed <= 1'b0;
`endif
                  end
               end
               DOWN: begin
                  step_tick <= 1'b1;
                  if (dn_bot) begin
                     fre <= start_l; state <= UP;
`ifdef FRE_SWEEP_MARKER_EN
                     marker <= (start_l >= mk_l);
                     armed  <= !(start_l >= mk_l);
`endif
                  end else begin
                     fre <= diff[FRE_W-1:0];
`ifdef FRE_SWEEP_MARKER_EN
                     marker <= armed && (diff[FRE_W-1:0] <= mk_l);
                     if (diff[FRE_W-1:0] <= mk_l) armed <= 1'b0;
`endif
                  end
               end
               FINISH: begin
                  state <= IDLE; busy <= 1'b0; done <= 1'b1;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fre_sweep.sv
// Directed bench for fre_sweep: hand-computed fre/step_tick/busy/done sequences.
module tb_fre_sweep;
   logic        clk_100M = 1'b0;
   logic        rst = 1'b1, start = 1'b0, stop = 1'b0;
   logic [23:0] f_start = '0, f_stop = '0, f_step = '0, dwell = '0;
   logic [1:0]  mode = '0;
   logic [23:0] fre;
   logic        busy, done, step_tick;
   int          checks = 0, errors = 0;
`ifdef FRE_SWEEP_MARKER_EN
   logic [23:0] f_marker = '0;
   logic        marker;
`endif

   fre_sweep dut (
      .clk_100M(clk_100M), .rst(rst), .start(start), .stop(stop),
      .f_start(f_start), .f_stop(f_stop), .f_step(f_step), .dwell(dwell), .mode(mode),
      .fre(fre), .busy(busy), .done(done), .step_tick(step_tick)
`ifdef FRE_SWEEP_MARKER_EN
      , .f_marker(f_marker), .marker(marker)
`endif
   );

   always #5 clk_100M = ~clk_100M;

   task automatic tick();
      @(posedge clk_100M);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic go(input logic [23:0] fs, input logic [23:0] fe, input logic [23:0] st,
                     input logic [23:0] dw, input logic [1:0] md);
      f_start = fs; f_stop = fe; f_step = st; dwell = dw; mode = md;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic do_stop();
      stop = 1'b1;
      tick();
      stop = 1'b0;
   endtask

   initial begin
      logic [23:0] tri_seq [8];
      tri_seq = '{24'd100, 24'd110, 24'd120, 24'd130, 24'd120, 24'd110, 24'd100, 24'd110};

      tick(); tick();
      rst = 1'b0;
      chk("rst_fre", fre, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_tick", step_tick, 0);

      // single sweep 1000..1040 step 10 dwell 3
      go(24'd1000, 24'd1040, 24'd10, 24'd3, 2'd0);
      for (int k = 0; k < 5; k++)
         for (int c = 0; c < 3; c++) begin
            chk("single_fre", fre, 1000 + 10 * k);
            chk("single_tick", step_tick, (c == 0) ? 1 : 0);
            chk("single_busy", busy, 1);
            chk("single_done", done, 0);
            tick();
         end
      chk("single_done_pulse", done, 1);
      chk("single_busy_low", busy, 0);
      chk("single_fre_hold", fre, 1040);
      tick();
      chk("single_done_once", done, 0);

      // overshoot clamp to f_stop
      go(24'd0, 24'd25, 24'd10, 24'd1, 2'd0);
      chk("clamp_fre0", fre, 0);  tick();
      chk("clamp_fre1", fre, 10); tick();
      chk("clamp_fre2", fre, 20); tick();
      chk("clamp_fre3", fre, 25);
      chk("clamp_tick3", step_tick, 1); tick();
      chk("clamp_done", done, 1);
      chk("clamp_busy", busy, 0);

      // triangle, then stop
      go(24'd100, 24'd130, 24'd10, 24'd2, 2'd2);
      for (int i = 0; i < 8; i++) begin
         chk("tri_fre", fre, tri_seq[i]);
         chk("tri_busy", busy, 1);
         if (i < 7) begin tick(); tick(); end
      end
      do_stop();
      chk("tri_stop_fre", fre, 110);
      chk("tri_stop_busy", busy, 0);
      chk("tri_stop_done", done, 1);
      chk("tri_stop_tick", step_tick, 0);
      tick();
      chk("tri_stop_done_once", done, 0);
      chk("tri_stop_frozen", fre, 110);

      // repeat with carry out of the adder
      go(24'hFFFFF0, 24'hFFFFFF, 24'h20, 24'd1, 2'd1);
      chk("rep_fre0", fre, 32'hFFFFF0); tick();
      chk("rep_fre1", fre, 32'hFFFFFF); tick();
      chk("rep_fre2", fre, 32'hFFFFF0); tick();
      chk("rep_fre3", fre, 32'hFFFFFF);
      chk("rep_busy", busy, 1);
      do_stop();
      chk("rep_stop_done", done, 1);

      // simultaneous start and stop in idle: nothing happens
      f_start = 24'd5; f_stop = 24'd50; f_step = 24'd5; dwell = 24'd1; mode = 2'd0;
      start = 1'b1; stop = 1'b1;
      tick();
      start = 1'b0; stop = 1'b0;
      chk("ss_busy", busy, 0);
      chk("ss_fre", fre, 32'hFFFFFF);
      chk("ss_tick", step_tick, 0);
      chk("ss_done", done, 0);

      // start while busy is ignored
      go(24'd1000, 24'd1040, 24'd10, 24'd1, 2'd0);
      f_start = 24'd5000; f_step = 24'd100; start = 1'b1;
      tick();
      start = 1'b0;
      chk("rebusy_fre1", fre, 1010);
      tick();
      chk("rebusy_fre2", fre, 1020);
      chk("rebusy_busy", busy, 1);
      do_stop();

      // zero step: one dwell at f_start then done
      go(24'd700, 24'd900, 24'd0, 24'd2, 2'd0);
      chk("zstep_fre", fre, 700);
      chk("zstep_busy", busy, 1); tick();
      chk("zstep_busy1", busy, 1);
      chk("zstep_nodone", done, 0); tick();
      chk("zstep_done", done, 1);
      chk("zstep_busy0", busy, 0);
      chk("zstep_fre_end", fre, 700);

      // reset mid-sweep
      go(24'd100, 24'd130, 24'd10, 24'd1, 2'd2);
      tick(); tick();
      chk("prerst_fre", fre, 120);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_fre", fre, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_tick", step_tick, 0);

`ifdef FRE_SWEEP_MARKER_EN
      begin
         int pulses = 0;
         f_marker = 24'd1015;
         go(24'd1000, 24'd1040, 24'd10, 24'd1, 2'd0);
         for (int k = 0; k < 5; k++) begin
            chk("mk_pulse", marker, (k == 2) ? 1 : 0);
            if (marker) pulses++;
            tick();
         end
         chk("mk_count", pulses, 1);
      end
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
